// File: rtl/clk_div_cfg_ctrl_pkg.sv
// rtl/clk_div_cfg_ctrl_pkg.sv - shared constants and FSM encoding for the clock-divider control stage
package clk_div_cfg_ctrl_pkg;

    // Ratio field width; must track the divider's WIDTH
    localparam int CLK_DIV_WIDTH = 8;

    // Ratios below this value put the divider in bypass (no division, no phase)
    localparam int MIN_DIV_RATIO = 2;

    typedef enum logic [1:0] {
        ST_STOPPED   = 2'd0,
        ST_RUN       = 2'd1,
        ST_STOP_PEND = 2'd2
    } clk_cfg_state_e;

endpackage

// File: rtl/clk_div_cfg_ctrl_phase_cnt.sv
// rtl/clk_div_cfg_ctrl_phase_cnt.sv - phase counter mirroring the divider period, with boundary detect
//
// Ports:
//   i_ref_clk   reference clock (same as the divider)
//   i_rst_n     asynchronous active-low reset
//   i_clk_en    committed divider enable
//   i_div_ratio committed divider ratio
//   i_clr       restart the period (ratio commit)
//   o_active    divider is enabled and actually dividing (ratio >= 2)
//   o_bnd       current cycle is the last one of a divided period
module clk_div_phase_cnt
    import clk_div_cfg_ctrl_pkg::*;
#(
    parameter int WIDTH = CLK_DIV_WIDTH
) (
    input  logic             i_ref_clk,
    input  logic             i_rst_n,
    input  logic             i_clk_en,
    input  logic [WIDTH-1:0] i_div_ratio,
    input  logic             i_clr,
    output logic             o_active,
    output logic             o_bnd
);

    logic [WIDTH-1:0] ph;

    assign o_active = i_clk_en && (i_div_ratio >= WIDTH'(MIN_DIV_RATIO));
    // ratio >= 2 whenever o_active, so ratio-1 cannot wrap
    assign o_bnd    = o_active && (ph == i_div_ratio - WIDTH'(1));

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ph <= '0;
        end else if (i_clr || !o_active || o_bnd) begin
            ph <= '0;
        end else begin
            ph <= ph + WIDTH'(1);
        end
    end

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// rtl/clk_div_cfg_ctrl.sv - glitch-free ratio/enable commit stage in front of the integer clock divider
//
// Ports:
//   i_ref_clk    reference clock (same as the divider)
//   i_rst_n      asynchronous active-low reset (same net as the divider)
//   i_cfg_valid  one-cycle strobe qualifying i_cfg_ratio
//   i_cfg_ratio  requested ratio (0/1 = bypass)
//   i_en         level enable request
//   o_div_ratio  committed ratio to the divider
//   o_clk_en     committed enable to the divider
//   o_busy       a ratio change or stop is still pending
//   o_done       one-cycle pulse after a ratio commit
module clk_div_cfg_ctrl
    import clk_div_cfg_ctrl_pkg::*;
#(
    parameter int          WIDTH     = CLK_DIV_WIDTH,
    parameter int unsigned RST_RATIO = 1
) (
    input  logic             i_ref_clk,
    input  logic             i_rst_n,
    input  logic             i_cfg_valid,
    input  logic [WIDTH-1:0] i_cfg_ratio,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_div_ratio,
    output logic             o_clk_en,
    output logic             o_busy,
    output logic             o_done
);

    clk_cfg_state_e   state;
    logic [WIDTH-1:0] shadow;
    logic             pend_ratio;
    logic             active;
    logic             bnd;
    logic             commit;
    logic             pend_ratio_nxt;
    logic             stop_pend_nxt;

    clk_div_phase_cnt #(
        .WIDTH (WIDTH)
    ) u_phase_cnt (
        .i_ref_clk   (i_ref_clk),
        .i_rst_n     (i_rst_n),
        .i_clk_en    (o_clk_en),
        .i_div_ratio (o_div_ratio),
        .i_clr       (commit),
        .o_active    (active),
        .o_bnd       (bnd)
    );

    // Changes land only where the divider is back in its reset state:
    // at a period boundary, or anytime it is not dividing.
    assign commit         = pend_ratio && (bnd || !active);
    // A strobe on the commit edge is consumed by that commit
    assign pend_ratio_nxt = !commit && (pend_ratio || i_cfg_valid);

    always_comb begin
        stop_pend_nxt = 1'b0;
        case (state)
            ST_RUN:       stop_pend_nxt = !i_en;
            ST_STOP_PEND: stop_pend_nxt = !i_en && !(bnd || !active);
            default:      stop_pend_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_STOPPED;
            o_clk_en    <= 1'b0;
            o_div_ratio <= WIDTH'(RST_RATIO);
            shadow      <= WIDTH'(RST_RATIO);
            pend_ratio  <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            if (i_cfg_valid) begin
                shadow <= i_cfg_ratio;
            end
            if (commit) begin
                // Latest request wins, including one arriving on the commit edge
                o_div_ratio <= i_cfg_valid ? i_cfg_ratio : shadow;
            end
            pend_ratio <= pend_ratio_nxt;
            o_done     <= commit;
            o_busy     <= pend_ratio_nxt || stop_pend_nxt;

            case (state)
                ST_STOPPED: begin
                    if (i_en) begin
                        state    <= ST_RUN;
                        o_clk_en <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!i_en) begin
                        state <= ST_STOP_PEND;
                    end
                end
                ST_STOP_PEND: begin
                    if (i_en) begin
                        state <= ST_RUN;
                    end else if (bnd || !active) begin
                        // Dropping enable at the boundary freezes the divider low
                        state    <= ST_STOPPED;
                        o_clk_en <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_STOPPED;
                    o_clk_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
